// File: rtl/mem_port_seq_if.sv
// Byte-wide valid/ready memory bus between mem_port_seq (master) and a memory model (slave).
interface mem_port_seq_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_we;
  logic              bus_valid;
  logic              bus_ready;
  logic [7:0]        bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_valid,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_valid,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_port_seq.sv
// Splits one 32-bit MIPS memory access into four little-endian byte beats; busy stalls the datapath.
// MISALIGN_TRAP_EN: misaligned requests skip the bus and pulse err with done; otherwise addresses are forced word-aligned.
module mem_port_seq #(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] IR_RESET = 32'h00000000
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic          ir_dest,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   Instr,
  output logic [31:0]   rdata,
  mem_port_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q;
  logic [1:0]          beat_q;
  logic [1:0]          beat_d;
  logic [ADDR_W-3:0]   base_q;
  logic                we_q;
  logic                ir_dest_q;
  logic [31:0]         wdata_q;
  logic [23:0]         asm_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                bus_valid_q;
  logic                bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [7:0]          bus_wdata_q;
  logic [31:0]         instr_q;
  logic [31:0]         rdata_q;
  logic                misalign;
  logic                unused_addr;

`ifdef MISALIGN_TRAP_EN
  assign misalign = (addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign unused_addr = ^{addr[31:ADDR_W], addr[1:0]};
  assign beat_d      = beat_q + 2'd1;

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      base_q      <= '0;
      we_q        <= 1'b0;
      ir_dest_q   <= 1'b0;
      wdata_q     <= '0;
      asm_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      instr_q     <= IR_RESET;
      rdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            if (misalign) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= XFER;
              base_q      <= addr[ADDR_W-1:2];
              we_q        <= we;
              ir_dest_q   <= ir_dest;
              wdata_q     <= wdata;
              beat_q      <= 2'd0;
              bus_valid_q <= 1'b1;
              bus_we_q    <= we;
              bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wdata_q <= wdata[7:0];
            end
          end
        end
        XFER: begin
          if (bus_valid_q && bus.bus_ready) begin
            if (!we_q) begin
              case (beat_q)
                2'd0:    asm_q[7:0]   <= bus.bus_rdata;
                2'd1:    asm_q[15:8]  <= bus.bus_rdata;
                2'd2:    asm_q[23:16] <= bus.bus_rdata;
                default: ;
              endcase
            end
            if (beat_q == 2'd3) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              bus_valid_q <= 1'b0;
              bus_we_q    <= 1'b0;
              // Last byte comes straight off the bus so the word lands on the same edge.
              if (!we_q) begin
                if (ir_dest_q) instr_q <= {bus.bus_rdata, asm_q};
                else           rdata_q <= {bus.bus_rdata, asm_q};
              end
            end else begin
              beat_q      <= beat_d;
              bus_addr_q  <= {base_q, beat_d};
              bus_wdata_q <= wdata_q[{beat_d, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign Instr         = instr_q;
  assign rdata         = rdata_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_port_seq.sv
// Directed bench for mem_port_seq: read/write sequencing, bus stalls, reset abort, back-to-back and misaligned requests.
module tb_mem_port_seq;

  logic        cclk;
  logic        rst;
  logic        req;
  logic        we;
  logic        ir_dest;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] Instr;
  logic [31:0] rdata;
  logic [7:0]  rd_bytes [4];

  int errors = 0;
  int checks = 0;

  mem_port_seq_if #(.ADDR_W(16)) bus_if ();

  mem_port_seq #(.ADDR_W(16), .IR_RESET(32'h00000000)) dut (
    .cclk    (cclk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .ir_dest (ir_dest),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .Instr   (Instr),
    .rdata   (rdata),
    .bus     (bus_if)
  );

  // Memory model returns the byte for the lane currently addressed.
  assign bus_if.bus_rdata = rd_bytes[bus_if.bus_addr[1:0]];

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; ir_dest = 1'b0; addr = '0; wdata = '0;
    bus_if.bus_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err); end
    checks++; if (bus_if.bus_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", bus_if.bus_valid); end
    checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", bus_if.bus_we); end
    checks++; if (bus_if.bus_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%0h exp=0", bus_if.bus_addr); end
    checks++; if (bus_if.bus_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got=%0h exp=0", bus_if.bus_wdata); end
    checks++; if (Instr !== 32'h00000000) begin errors++; $display("FAIL rst_instr got=%0h exp=0", Instr); end
    checks++; if (rdata !== 32'h00000000) begin errors++; $display("FAIL rst_rdata got=%0h exp=0", rdata); end
  endtask

  // Read into Instr; req accepted at edge N, done visible after edge N+4 and gone after N+5.
  task automatic test_read_instr();
    rd_bytes[0] = 8'h20; rd_bytes[1] = 8'h10; rd_bytes[2] = 8'h08; rd_bytes[3] = 8'h01;
    req = 1'b1; we = 1'b0; ir_dest = 1'b1; addr = 32'h0000_0040;
    tick();
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rdi_busy got=%0h exp=1", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_if.bus_addr !== 16'h0040 + 16'(i)) begin errors++; $display("FAIL rdi_addr%0d got=%0h exp=%0h", i, bus_if.bus_addr, 16'h0040 + 16'(i)); end
      checks++; if (bus_if.bus_valid !== 1'b1 || bus_if.bus_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rdi_ctl%0d got=%0h%0h%0h exp=100", i, bus_if.bus_valid, bus_if.bus_we, done); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b1 || bus_if.bus_valid !== 1'b0) begin errors++; $display("FAIL rdi_done got=%0h%0h%0h exp=110", done, busy, bus_if.bus_valid); end
    checks++; if (Instr !== 32'h01081020) begin errors++; $display("FAIL rdi_instr got=%0h exp=01081020", Instr); end
    checks++; if (rdata !== 32'h00000000) begin errors++; $display("FAIL rdi_rdata got=%0h exp=0", rdata); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rdi_idle got=%0h%0h exp=00", done, busy); end
  endtask

  task automatic test_write_waits();
    req = 1'b1; we = 1'b1; ir_dest = 1'b1; addr = 32'h0000_0100; wdata = 32'hDEADBEEF;
    tick();
    req = 1'b0;
    checks++; if (bus_if.bus_addr !== 16'h0100 || bus_if.bus_wdata !== 8'hEF || bus_if.bus_we !== 1'b1) begin errors++; $display("FAIL wr_b0 got=%0h/%0h/%0h exp=100/ef/1", bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_we); end
    tick();
    bus_if.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_if.bus_addr !== 16'h0101 || bus_if.bus_wdata !== 8'hBE || bus_if.bus_valid !== 1'b1) begin errors++; $display("FAIL wr_hold%0d got=%0h/%0h/%0h exp=101/be/1", i, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_valid); end
      if (i < 2) tick();
    end
    bus_if.bus_ready = 1'b1;
    tick();
    checks++; if (bus_if.bus_addr !== 16'h0102 || bus_if.bus_wdata !== 8'hAD) begin errors++; $display("FAIL wr_b2 got=%0h/%0h exp=102/ad", bus_if.bus_addr, bus_if.bus_wdata); end
    tick();
    checks++; if (bus_if.bus_addr !== 16'h0103 || bus_if.bus_wdata !== 8'hDE || done !== 1'b0) begin errors++; $display("FAIL wr_b3 got=%0h/%0h/%0h exp=103/de/0", bus_if.bus_addr, bus_if.bus_wdata, done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_done got=%0h exp=1", done); end
    checks++; if (Instr !== 32'h01081020 || rdata !== 32'h00000000) begin errors++; $display("FAIL wr_regs got=%0h/%0h exp=01081020/0", Instr, rdata); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle got=%0h%0h exp=00", done, busy); end
  endtask

  task automatic test_read_rdata_wrap();
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    req = 1'b1; we = 1'b0; ir_dest = 1'b0; addr = 32'h0000_FFFC;
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_if.bus_addr !== 16'hFFFC + 16'(i)) begin errors++; $display("FAIL wrap_addr%0d got=%0h exp=%0h", i, bus_if.bus_addr, 16'hFFFC + 16'(i)); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%0h exp=1", done); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL wrap_rdata got=%0h exp=44332211", rdata); end
    checks++; if (Instr !== 32'h01081020) begin errors++; $display("FAIL wrap_instr got=%0h exp=01081020", Instr); end
    tick();
  endtask

  task automatic test_reset_mid();
    rd_bytes[0] = 8'h55; rd_bytes[1] = 8'h66; rd_bytes[2] = 8'h77; rd_bytes[3] = 8'h88;
    req = 1'b1; we = 1'b0; ir_dest = 1'b1; addr = 32'h0000_0080;
    tick();
    req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus_if.bus_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_ctl got=%0h%0h%0h exp=000", bus_if.bus_valid, busy, done); end
    checks++; if (Instr !== 32'h00000000 || rdata !== 32'h00000000) begin errors++; $display("FAIL rmid_regs got=%0h/%0h exp=0/0", Instr, rdata); end
    rd_bytes[0] = 8'hAA; rd_bytes[1] = 8'hBB; rd_bytes[2] = 8'hCC; rd_bytes[3] = 8'hDD;
    req = 1'b1; ir_dest = 1'b0; addr = 32'h0000_0084;
    tick();
    req = 1'b0;
    checks++; if (bus_if.bus_addr !== 16'h0084 || bus_if.bus_valid !== 1'b1) begin errors++; $display("FAIL rmid_restart got=%0h/%0h exp=84/1", bus_if.bus_addr, bus_if.bus_valid); end
    tick(); tick(); tick(); tick();
    checks++; if (done !== 1'b1 || rdata !== 32'hDDCCBBAA || Instr !== 32'h00000000) begin errors++; $display("FAIL rmid_fresh got=%0h/%0h/%0h exp=1/ddccbbaa/0", done, rdata, Instr); end
    tick();
  endtask

  task automatic test_back_to_back();
    rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h02; rd_bytes[2] = 8'h03; rd_bytes[3] = 8'h04;
    req = 1'b1; we = 1'b0; ir_dest = 1'b1; addr = 32'h0000_0010;
    tick();
    addr = 32'h0000_0020;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_if.bus_addr !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL b2b_addr%0d got=%0h exp=%0h", i, bus_if.bus_addr, 16'h0010 + 16'(i)); end
      tick();
    end
    checks++; if (done !== 1'b1 || Instr !== 32'h04030201) begin errors++; $display("FAIL b2b_first got=%0h/%0h exp=1/04030201", done, Instr); end
    rd_bytes[0] = 8'h05; rd_bytes[1] = 8'h06; rd_bytes[2] = 8'h07; rd_bytes[3] = 8'h08;
    tick();
    checks++; if (busy !== 1'b0 || bus_if.bus_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%0h%0h%0h exp=000", busy, bus_if.bus_valid, done); end
    tick();
    req = 1'b0;
    checks++; if (busy !== 1'b1 || bus_if.bus_valid !== 1'b1 || bus_if.bus_addr !== 16'h0020) begin errors++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/1/20", busy, bus_if.bus_valid, bus_if.bus_addr); end
    tick(); tick(); tick(); tick();
    checks++; if (done !== 1'b1 || Instr !== 32'h08070605) begin errors++; $display("FAIL b2b_done2 got=%0h/%0h exp=1/08070605", done, Instr); end
    tick();
  endtask

  task automatic test_misaligned();
    rd_bytes[0] = 8'h9A; rd_bytes[1] = 8'hBC; rd_bytes[2] = 8'hDE; rd_bytes[3] = 8'hF0;
    req = 1'b1; we = 1'b0; ir_dest = 1'b0; addr = 32'h0000_0042;
    tick();
    req = 1'b0;
`ifdef MISALIGN_TRAP_EN
    checks++; if (bus_if.bus_valid !== 1'b0 || err !== 1'b1 || done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mis_trap got=%0h%0h%0h%0h exp=0111", bus_if.bus_valid, err, done, busy); end
    tick();
    checks++; if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bus_if.bus_valid !== 1'b0) begin errors++; $display("FAIL mis_after got=%0h%0h%0h%0h exp=0000", err, done, busy, bus_if.bus_valid); end
    checks++; if (Instr !== 32'h08070605 || rdata !== 32'hDDCCBBAA) begin errors++; $display("FAIL mis_regs got=%0h/%0h exp=08070605/ddccbbaa", Instr, rdata); end
`else
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_if.bus_addr !== 16'h0040 + 16'(i) || err !== 1'b0) begin errors++; $display("FAIL mis_beat%0d got=%0h/%0h exp=%0h/0", i, bus_if.bus_addr, err, 16'h0040 + 16'(i)); end
      tick();
    end
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hF0DEBC9A) begin errors++; $display("FAIL mis_done got=%0h/%0h/%0h exp=1/0/f0debc9a", done, err, rdata); end
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_instr();
    test_write_waits();
    test_read_rdata_wrap();
    test_reset_mid();
    test_back_to_back();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
